// File: rtl/axi4_stream_fifo.sv
// AXI4-Stream FIFO with fill level, stored-packet count and an optional
// store-and-forward mode that holds output until a whole packet is buffered.
module axi4_stream_fifo #(
  parameter int DW       = 8,
  parameter int DEPTH    = 16,
  parameter int PKT_MODE = 0
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [DW-1:0]              s_tdata,
  input  logic                       s_tkeep,
  input  logic                       s_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DW-1:0]              m_tdata,
  output logic                       m_tkeep,
  output logic                       m_tlast,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     pkt_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW+1:0] mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] pkt_cnt_r;
  logic          draining_r;

  logic          full_s;
  logic          empty_s;
  logic          valid_s;
  logic          push_s;
  logic          pop_s;
  logic          push_last_s;
  logic          pop_last_s;
  logic [DW+1:0] head_s;

  // Status, handshakes and head-of-queue decode from the registered pointers.
  always_comb begin
    full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    empty_s = (wr_ptr_r == rd_ptr_r);
    if (PKT_MODE != 0) begin
      // A full FIFO with no complete packet cuts through to avoid deadlock.
      valid_s = !empty_s && ((pkt_cnt_r != {LW{1'b0}}) || full_s || draining_r);
    end else begin
      valid_s = !empty_s;
    end
    head_s      = mem_r[rd_ptr_r[AW-1:0]];
    push_s      = s_tvalid && !full_s;
    pop_s       = valid_s && m_tready;
    push_last_s = push_s && s_tlast;
    pop_last_s  = pop_s && head_s[DW];
  end

  assign s_tready = !full_s || !ARESETn;
  assign m_tvalid = valid_s;
  assign m_tdata  = head_s[DW-1:0];
  assign m_tlast  = head_s[DW];
  assign m_tkeep  = head_s[DW+1];
  assign level    = level_r;
  assign pkt_cnt  = pkt_cnt_r;

  // Beat storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge ACLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {s_tkeep, s_tlast, s_tdata};
    end
  end

  // Pointers, level, packet count and cut-through flag.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      level_r    <= {LW{1'b0}};
      pkt_cnt_r  <= {LW{1'b0}};
      draining_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + {{(LW-1){1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{(LW-1){1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
      pkt_cnt_r <= pkt_cnt_r + {{(LW-1){1'b0}}, push_last_s} - {{(LW-1){1'b0}}, pop_last_s};
      if (pop_last_s) begin
        draining_r <= 1'b0;
      end else if (full_s && (pkt_cnt_r == {LW{1'b0}})) begin
        draining_r <= 1'b1;
      end else begin
        draining_r <= draining_r;
      end
    end
  end

endmodule

// File: tb/tb_axi4_stream_fifo.sv
// Directed bench for axi4_stream_fifo: instance 0 in fall-through mode,
// instance 1 in store-and-forward mode, both checked against a queue model.
module tb_axi4_stream_fifo;

  localparam int DEPTH = 16;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic [1:0] s_tvalid, s_tready, s_tkeep, s_tlast;
  logic [1:0] m_tvalid, m_tready, m_tkeep, m_tlast;
  logic [7:0] s_tdata [2];
  logic [7:0] m_tdata [2];
  logic [4:0] level   [2];
  logic [4:0] pkt_cnt [2];

  int         n_cmp = 0;
  int         n_err = 0;
  int         sel   = 0;
  logic [9:0] q [$];
  logic       drain = 1'b0;

  always #5 ACLK = ~ACLK;

  axi4_stream_fifo #(.DW(8), .DEPTH(DEPTH), .PKT_MODE(0)) u_ff0 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]), .s_tdata(s_tdata[0]),
    .s_tkeep(s_tkeep[0]), .s_tlast(s_tlast[0]),
    .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .m_tdata(m_tdata[0]),
    .m_tkeep(m_tkeep[0]), .m_tlast(m_tlast[0]),
    .level(level[0]), .pkt_cnt(pkt_cnt[0])
  );

  axi4_stream_fifo #(.DW(8), .DEPTH(DEPTH), .PKT_MODE(1)) u_ff1 (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]), .s_tdata(s_tdata[1]),
    .s_tkeep(s_tkeep[1]), .s_tlast(s_tlast[1]),
    .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .m_tdata(m_tdata[1]),
    .m_tkeep(m_tkeep[1]), .m_tlast(m_tlast[1]),
    .level(level[1]), .pkt_cnt(pkt_cnt[1])
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int npk();
    int n = 0;
    foreach (q[i]) if (q[i][8]) n++;
    return n;
  endfunction

  // One clock cycle on the selected instance; called 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic k,
                      input logic rdy, output logic acc);
    logic [9:0] head;
    logic       exp_rdy, exp_vld, popped_last;
    int         pk;
    s_tvalid[sel] = v; s_tdata[sel] = d; s_tlast[sel] = l; s_tkeep[sel] = k;
    m_tready[sel] = rdy;
    #4;
    pk      = npk();
    exp_rdy = (q.size() != DEPTH);
    exp_vld = (q.size() != 0) && ((sel == 0) || (pk > 0) || !exp_rdy || drain);
    check("s_tready", 16'(s_tready[sel]), 16'(exp_rdy));
    check("m_tvalid", 16'(m_tvalid[sel]), 16'(exp_vld));
    popped_last = 1'b0;
    if (exp_vld && rdy) begin
      head = q.pop_front();
      check("m_beat", {6'd0, m_tkeep[sel], m_tlast[sel], m_tdata[sel]}, {6'd0, head});
      popped_last = head[8];
    end
    if (popped_last) drain = 1'b0;
    else if (!exp_rdy && pk == 0) drain = 1'b1;
    acc = v && exp_rdy;
    if (acc) q.push_back({k, l, d});
    @(posedge ACLK); #1;
    s_tvalid[sel] = 1'b0; s_tlast[sel] = 1'b0;
    check("level", 16'(level[sel]), 16'(q.size()));
    check("pkt_cnt", 16'(pkt_cnt[sel]), 16'(npk()));
  endtask

  // Holds reset for n edges while offering beats, then checks the idle state.
  task automatic do_reset(input int n);
    ARESETn = 1'b0;
    s_tvalid = 2'b11; s_tlast = 2'b11; s_tkeep = 2'b00; m_tready = 2'b00;
    s_tdata[0] = 8'h5A; s_tdata[1] = 8'hA5;
    repeat (n) @(posedge ACLK);
    #1;
    ARESETn = 1'b1; s_tvalid = 2'b00; s_tlast = 2'b00;
    q.delete(); drain = 1'b0;
    #4;
    for (int i = 0; i < 2; i++) begin
      check("rst_s_tready", 16'(s_tready[i]), 16'd1);
      check("rst_m_tvalid", 16'(m_tvalid[i]), 16'd0);
      check("rst_level", 16'(level[i]), 16'd0);
      check("rst_pkt_cnt", 16'(pkt_cnt[i]), 16'd0);
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    logic acc;
    int   i;
    s_tvalid = 2'b00; s_tlast = 2'b00; s_tkeep = 2'b00; m_tready = 2'b00;
    s_tdata[0] = 8'h00; s_tdata[1] = 8'h00;
    do_reset(3);

    // Streaming in fall-through mode.
    sel = 0;
    for (i = 0; i < 40; i++) step(1'b1, 8'(8'h80 + i), (i % 8) == 7, 1'(i), 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

    // Fill with the sink stalled, then drain with a 2-low/6-high ready pattern.
    i = 0;
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 8'(8'h10 + i), (i % 5) == 4, 1'(i >> 1), 1'b0, acc);
      if (acc) i++;
    end
    check("fill_level", 16'(level[0]), 16'd16);
    for (int c = 0; c < 100 && (i < 20 || q.size() != 0); c++) begin
      step(i < 20, 8'(8'h10 + i), (i % 5) == 4, 1'(i >> 1), (c % 8) >= 2, acc);
      if (acc) i++;
    end
    check("drain_done", 16'(level[0]), 16'd0);

    // Pointer wrap with concurrent push and pop.
    for (int c = 0; c < 3 * DEPTH; c++)
      step(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

    // Store-and-forward: 5-beat packet with idle gaps.
    do_reset(1);
    sel = 1;
    for (i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'hC0 + i), i == 4, 1'b1, 1'b1, acc);
      if (i < 4) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    end
    for (int c = 0; c < 6; c++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

    // Oversize packet forces cut-through once full.
    i = 0;
    for (int c = 0; c < 80 && (i < 24 || q.size() != 0); c++) begin
      step(i < 24, 8'(8'h40 + i), i == 23, 1'(i), 1'b1, acc);
      if (acc) i++;
    end
    check("ovr_done", 16'(level[1]), 16'd0);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

    // Mid-operation reset with a complete packet pending.
    do_reset(1);
    for (i = 0; i < 10; i++) step(1'b1, 8'(8'h60 + i), i == 4, 1'b0, 1'b0, acc);
    do_reset(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_stream_fifo.md
# axi4_stream_fifo

Synchronous AXI4-Stream FIFO placed between an AXI4-Stream master and slave on the `axi4_stream_if` bus (DN=1, DT=signed 8-bit). It decouples master and slave backpressure and reports fill level. An optional store-and-forward packet mode withholds output until a complete TLAST-terminated packet is buffered. Its purpose is to absorb slave TREADY gaps, such as an oscillating low/high ready pattern, without stalling the master.

## Interface
- `DW`, 8: TDATA width in bits. Data is carried opaquely; signedness is irrelevant inside the block.
- `DEPTH`, 16: entry count. Must be a power of 2 and at least 2.
- `PKT_MODE`, 0: 0 = first-word fall-through; 1 = store-and-forward.
- `ACLK`  in  1  single clock; all logic is clocked on the rising edge.
- `ARESETn`  in  1  synchronous, active-low reset.
- `s_tvalid`  in  1  upstream beat valid.
- `s_tready`  out  1  FIFO can accept a beat.
- `s_tdata`  in  DW  upstream data.
- `s_tkeep`  in  1  upstream byte qualifier; stored with the beat.
- `s_tlast`  in  1  end of packet.
- `m_tvalid`  out  1  beat available downstream.
- `m_tready`  in  1  downstream accept.
- `m_tdata`  out  DW  head-of-FIFO data.
- `m_tkeep`  out  1  head-of-FIFO keep.
- `m_tlast`  out  1  head-of-FIFO last.
- `level`  out  $clog2(DEPTH)+1  stored beat count, range 0..DEPTH.
- `pkt_cnt`  out  $clog2(DEPTH)+1  complete packets stored (TLAST beats held).

## Operation
- **Storage:** array of DEPTH × (DW+2) bits. Write pointer and read pointer are $clog2(DEPTH)+1 bits each, with an extra wrap bit.
  - empty = pointers equal.
  - full = addresses equal and wrap bits differ.
- **Push** occurs when `s_tvalid && s_tready`. The entry is written at the write pointer, then the write pointer increments and wraps modulo 2·DEPTH.
- **Pop** occurs when `m_tvalid && m_tready`. The read pointer increments.
- **level** updates as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- **pkt_cnt** updates as follows:
  - +1 on a push with `s_tlast`.
  - −1 on a pop with `m_tlast`.
  - Net change on simultaneous events is the sum of the two.
- **s_tready** = !full, taken combinationally from the registered pointers.
  - When full, a simultaneous pop does not enable a push in the same cycle.
- **m_tvalid**:
  - PKT_MODE=0: !empty.
  - PKT_MODE=1: !empty && (pkt_cnt>0 || full || draining).
  - `draining` is a flag that sets when full is reached with pkt_cnt==0 and clears on a pop with `m_tlast`. This is a cut-through fallback that prevents deadlock on packets larger than DEPTH.
- **m_tdata/m_tkeep/m_tlast** are read combinationally from the read-pointer entry. They are don't-care when `m_tvalid`=0, but the bench checks them only under `m_tvalid`.
- **Ordering:** beats leave in arrival order. No beat is dropped or duplicated.

## Timing
- **Reset** (ARESETn low at a rising edge): both pointers = 0, level = 0, pkt_cnt = 0, draining = 0.
  - Hence s_tready=1 and m_tvalid=0 in the first cycle after reset.
  - s_tready is also 1 while reset is asserted. Beats pushed during reset are discarded.
- **Latency:** a beat pushed at edge N is presented with `m_tvalid`=1 after edge N (PKT_MODE=0).
  - Minimum pass-through latency is 1 cycle.
  - There is no combinational path from `s_*` to `m_*`.
- **Throughput:** 1 beat/cycle sustained when `m_tready`=1 and the FIFO is neither empty nor full.
- **Backpressure:** once `m_tvalid`=1 is asserted, `m_tvalid`, `m_tdata`, `m_tkeep` and `m_tlast` stay stable until the handshake.
  - Exception: reset mid-operation flushes all content and forces `m_tvalid` low on the next cycle.
- **Full** (level==DEPTH): s_tready=0. After a pop at edge N, s_tready=1 after edge N.
- **Empty** with a simultaneous push and `m_tready`=1: no pop that cycle; the beat appears the next cycle.
- **Wrap-around:** pointers roll from 2·DEPTH−1 to 0 with no bubble.

## Test plan
- **Reset then idle:** assert ARESETn=0 for 3 cycles, then release.
  - Required: s_tready=1, m_tvalid=0, level=0, pkt_cnt=0.
- **Streaming (PKT_MODE=0, m_tready=1):** push 40 beats, data 0x80..0xA7, tlast on every 8th beat.
  - Required: output order is identical with 1-cycle latency; level never exceeds 1; pkt_cnt returns to 0.
- **Fill and oscillating drain:** with m_tready=0, push 20 beats.
  - Required: s_tready=0 after beat 16, level=16.
  - Then drive m_tready low 2 / high 6 cycles repeating. Required: all 20 beats arrive in order and level reaches 0.
- **Wrap:** with m_tready=1, run 3·DEPTH push/pop pairs.
  - Required: level stays at 1 and there are no data mismatches across the pointer wrap.
- **Store-and-forward (PKT_MODE=1):** push a 5-beat packet with 1 idle cycle between beats.
  - Required: m_tvalid=0 until the cycle after the TLAST beat is pushed, then the 5 beats come out back-to-back and pkt_cnt goes 1→0 on the last pop.
- **Oversize packet (PKT_MODE=1):** push a 24-beat packet with m_tready=1.
  - Required: m_tvalid rises when level hits 16; all 24 beats exit in order; draining clears after the TLAST pop.
  - Mid-operation reset: assert ARESETn low at beat 10. Required: next cycle level=0, m_tvalid=0.
